// File: rtl/ab_game_top.sv
// 1A2B game core: latches a valid 4-digit guess in WAIT and scores it against SECRET.
// Latency: valid guess in WAIT -> out_valid 2 edges later; inputs are levels, there is no backpressure.
module ab_game_top #(
  parameter logic [15:0] SECRET = 16'h5423
) (
  input  logic       in_clk,
  input  logic       in_restart_n,
  input  logic       in_loadtest,
  input  logic       in_enter,
  input  logic [3:0] in_ans0,
  input  logic [3:0] in_ans1,
  input  logic [3:0] in_ans2,
  input  logic [3:0] in_ans3,
  output logic [2:0] out_Anum,
  output logic [2:0] out_Bnum,
  output logic [1:0] out_state,
  output logic       out_valid
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TEMP_TEST = 2'd1,
    WAIT      = 2'd2,
    RESULT    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ans     [4];
  logic [3:0] guess_q [4];
  logic [3:0] secret  [4];
  logic       ans_ok;
  logic [2:0] a_cnt, b_cnt;

  assign ans[0] = in_ans0;
  assign ans[1] = in_ans1;
  assign ans[2] = in_ans2;
  assign ans[3] = in_ans3;

  // Position 0 is the most significant nibble of SECRET.
  assign secret[0] = SECRET[15:12];
  assign secret[1] = SECRET[11:8];
  assign secret[2] = SECRET[7:4];
  assign secret[3] = SECRET[3:0];

  always_comb begin
    ans_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ans[i] > 4'd9) ans_ok = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (ans[i] == ans[j]) ans_ok = 1'b0;
      end
    end
  end

  always_comb begin
    a_cnt = 3'd0;
    b_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (guess_q[i] == secret[j]) begin
          if (i == j) a_cnt = a_cnt + 3'd1;
          else        b_cnt = b_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_restart_n) begin
    if (!in_restart_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_loadtest) state_d = TEMP_TEST;
      TEMP_TEST: if (in_enter)    state_d = WAIT;
      WAIT:      if (ans_ok)      state_d = RESULT;
      RESULT:                     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Scores are registered on the RESULT->IDLE edge, so out_valid pulses alongside them.
  always_ff @(posedge in_clk or negedge in_restart_n) begin
    if (!in_restart_n) begin
      for (int i = 0; i < 4; i++) guess_q[i] <= 4'd0;
      out_Anum  <= 3'd0;
      out_Bnum  <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == RESULT);
      if (state_q == WAIT && ans_ok) begin
        for (int i = 0; i < 4; i++) guess_q[i] <= ans[i];
      end
      if (state_q == RESULT) begin
        out_Anum <= a_cnt;
        out_Bnum <= b_cnt;
      end
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_ab_game_top.sv
// Bench for ab_game_top: fixed vector table, hand-written corner sequences and
// randomized guesses scored by a set-counting reference model.
module tb_ab_game_top;

  localparam logic [15:0] SECRET = 16'h5423;

  logic       clk;
  logic       rst_n;
  logic       loadtest;
  logic       enter;
  logic [3:0] ans0, ans1, ans2, ans3;
  logic [2:0] anum, bnum;
  logic [1:0] state;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_a = 0;
  int exp_b = 0;

  ab_game_top #(.SECRET(SECRET)) dut (
    .in_clk       (clk),
    .in_restart_n (rst_n),
    .in_loadtest  (loadtest),
    .in_enter     (enter),
    .in_ans0      (ans0),
    .in_ans1      (ans1),
    .in_ans2      (ans2),
    .in_ans3      (ans3),
    .out_Anum     (anum),
    .out_Bnum     (bnum),
    .out_state    (state),
    .out_valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] guess;
    int          a;
    int          b;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic set_ans(input logic [15:0] g);
    ans0 = g[15:12];
    ans1 = g[11:8];
    ans2 = g[7:4];
    ans3 = g[3:0];
  endtask

  // Reference model: validity and scoring by digit membership counting.
  function automatic bit model_ok(input logic [15:0] g);
    bit seen [16];
    for (int k = 0; k < 16; k++) seen[k] = 0;
    for (int i = 0; i < 4; i++) begin
      int d = int'(g[4*(3-i) +: 4]);
      if (d > 9 || seen[d]) return 0;
      seen[d] = 1;
    end
    return 1;
  endfunction

  function automatic void model_score(input logic [15:0] g, output int a, output int b);
    bit in_secret [16];
    int common;
    for (int k = 0; k < 16; k++) in_secret[k] = 0;
    for (int i = 0; i < 4; i++) in_secret[int'(SECRET[4*i +: 4])] = 1;
    a = 0;
    common = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[4*i +: 4] == SECRET[4*i +: 4]) a++;
      if (in_secret[int'(g[4*i +: 4])]) common++;
    end
    b = common - a;
  endfunction

  function automatic logic [15:0] rand_perm();
    int p [10];
    for (int i = 0; i < 10; i++) p[i] = i;
    for (int i = 9; i > 0; i--) begin
      int j = int'($urandom_range(i, 0));
      int t = p[i];
      p[i] = p[j];
      p[j] = t;
    end
    return {p[0][3:0], p[1][3:0], p[2][3:0], p[3][3:0]};
  endfunction

  // All tasks start just after a negedge: check what the previous posedge produced, then drive.
  task automatic arm();
    loadtest = 1'b1;
    @(negedge clk);
    chk("arm_state1", int'(state), 1);
    loadtest = 1'b0;
    enter    = 1'b1;
    @(negedge clk);
    chk("arm_state2", int'(state), 2);
    enter = 1'b0;
  endtask

  // Guess already accepted (state RESULT now): check the pulse and the hold.
  task automatic finish_result(input int ea, input int eb, input string nm);
    chk({nm, "_res_state3"}, int'(state), 3);
    chk({nm, "_res_valid0"}, int'(valid), 0);
    set_ans(16'hFFFF);
    @(negedge clk);
    chk({nm, "_state0"}, int'(state), 0);
    chk({nm, "_valid1"}, int'(valid), 1);
    chk({nm, "_A"}, int'(anum), ea);
    chk({nm, "_B"}, int'(bnum), eb);
    exp_a = ea;
    exp_b = eb;
    @(negedge clk);
    chk({nm, "_hold_valid0"}, int'(valid), 0);
    chk({nm, "_hold_A"}, int'(anum), ea);
    chk({nm, "_hold_B"}, int'(bnum), eb);
  endtask

  task automatic play(input logic [15:0] g, input int ea, input int eb, input string nm);
    arm();
    set_ans(g);
    @(negedge clk);
    finish_result(ea, eb, nm);
  endtask

  task automatic hold_invalid(input logic [15:0] g, input int cycles, input string nm);
    set_ans(g);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({nm, "_state2"}, int'(state), 2);
      chk({nm, "_valid0"}, int'(valid), 0);
      chk({nm, "_A_held"}, int'(anum), exp_a);
    end
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'h2345, 0, 4};
    vecs[1] = '{16'h5432, 2, 2};
    vecs[2] = '{16'h5428, 3, 0};
    vecs[3] = '{16'h5423, 4, 0};
    vecs[4] = '{16'h0189, 0, 0};
    vecs[5] = '{16'h3254, 0, 4};
    vecs[6] = '{16'h1423, 3, 0};
    vecs[7] = '{16'h0245, 0, 3};

    rst_n    = 1'b0;
    loadtest = 1'b0;
    enter    = 1'b0;
    set_ans(16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_A", int'(anum), 0);
    chk("rst_B", int'(bnum), 0);
    chk("rst_valid", int'(valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", int'(state), 0);

    // IDLE ignores enter; loadtest+enter goes only to TEMP_TEST.
    enter = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_enter_only", int'(state), 0);
    loadtest = 1'b1;
    @(negedge clk);
    chk("idle_both", int'(state), 1);
    enter = 1'b0;
    set_ans(16'h5423);
    repeat (2) @(negedge clk);
    chk("temp_ignores_load_ans", int'(state), 1);
    loadtest = 1'b0;
    enter    = 1'b1;
    @(negedge clk);
    chk("temp_to_wait", int'(state), 2);
    enter = 1'b0;
    set_ans(16'h5423);
    @(negedge clk);
    finish_result(4, 0, "first");

    for (int v = 0; v < 8; v++) begin
      play(vecs[v].guess, vecs[v].a, vecs[v].b, $sformatf("vec%0d", v));
    end

    // Invalid guesses park the FSM in WAIT until a valid one appears.
    arm();
    hold_invalid(16'h0000, 3, "inv0000");
    hold_invalid(16'h54C3, 5, "inv54C3");
    hold_invalid(16'h5523, 4, "inv5523");
    set_ans(16'h5432);
    @(negedge clk);
    finish_result(2, 2, "after_invalid");

    // Randomized games against the model.
    for (int it = 0; it < 30; it++) begin
      logic [15:0] g;
      bit          done;
      int          ea, eb;
      arm();
      done = 0;
      for (int t = 0; t < 8 && !done; t++) begin
        g = ($urandom_range(1, 0) == 1) ? rand_perm() : 16'($urandom());
        set_ans(g);
        @(negedge clk);
        if (model_ok(g)) begin
          model_score(g, ea, eb);
          finish_result(ea, eb, $sformatf("rnd%0d", it));
          done = 1;
        end else begin
          chk($sformatf("rnd%0d_wait", it), int'(state), 2);
          chk($sformatf("rnd%0d_wait_valid", it), int'(valid), 0);
        end
      end
      if (!done) begin
        g = rand_perm();
        model_score(g, ea, eb);
        set_ans(g);
        @(negedge clk);
        finish_result(ea, eb, $sformatf("rnd%0d_forced", it));
      end
    end

    // Asynchronous reset mid-WAIT with nonzero scores.
    play(16'h5428, 3, 0, "pre_rst");
    arm();
    set_ans(16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_A", int'(anum), 0);
    chk("midrst_B", int'(bnum), 0);
    chk("midrst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = 0;
    exp_b = 0;
    @(negedge clk);
    chk("post_rst_idle", int'(state), 0);
    play(16'h2345, 0, 4, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
